// File: rtl/spi_resp.sv
// 16-bit SPI responder: synchronizes SS_n/SCLK/MOSI into clk, captures the MOSI word, returns tx_hold on MISO.
// Optional SPI_RESP_TRISTATE_EN: MISO floats (1'bz) while idle instead of driving 0.
module spi_resp #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic             wrt,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rdy,
  output logic             frm_err,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SKIP, XFER} state_t;

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic                   ss_d, sclk_d;
  logic [SYNC_STAGES:0]   vld_pipe;
  logic                   armed;

  // Sync chains; idle-high lines reset high so reset release creates no false edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= '1;
      sclk_sync <= '1;
      mosi_sync <= '0;
      ss_d      <= 1'b1;
      sclk_d    <= 1'b1;
      vld_pipe  <= '0;
      armed     <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_d      <= ss_sync[SYNC_STAGES-1];
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      vld_pipe  <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      // Only arm once the pipe holds real pin data showing SS_n high, so a
      // frame already running at reset release is ignored.
      if (!armed && vld_pipe[SYNC_STAGES] && ss_d)
        armed <= 1'b1;
    end
  end

  logic ss_s, sclk_s, mosi_s;
  logic ss_fall, ss_rise, sclk_fall, sclk_rise;

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_fall   = armed &  ss_d   & ~ss_s;
  assign ss_rise   = armed & ~ss_d   &  ss_s;
  assign sclk_fall =  sclk_d & ~sclk_s;
  assign sclk_rise = ~sclk_d &  sclk_s;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tx_hold, tx_shft, tx_shft_nxt, rx_shft, rx_shft_nxt, rx_data_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt, cnt_inc;
  logic             rdy_nxt, err_nxt;

  assign cnt_inc = (bit_cnt == CNT_SAT) ? bit_cnt : bit_cnt + 1'b1;

  always_comb begin
    state_nxt   = state;
    tx_shft_nxt = tx_shft;
    rx_shft_nxt = rx_shft;
    bit_cnt_nxt = bit_cnt;
    rx_data_nxt = rx_data;
    rdy_nxt     = 1'b0;
    err_nxt     = 1'b0;
    unique case (state)
      IDLE: if (ss_fall) begin
        tx_shft_nxt = tx_hold;
        bit_cnt_nxt = '0;
        state_nxt   = SKIP;
      end
      SKIP: begin
        if (ss_rise) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (sclk_fall) begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (sclk_rise) begin
          rx_shft_nxt = {rx_shft[WIDTH-2:0], mosi_s};
          bit_cnt_nxt = cnt_inc;
        end
        if (sclk_fall)
          tx_shft_nxt = {tx_shft[WIDTH-2:0], 1'b0};
        // A rise coincident with ss_rise counts toward the frame
        if (ss_rise) begin
          if (bit_cnt_nxt == CNT_FULL) begin
            rx_data_nxt = rx_shft_nxt;
            rdy_nxt     = 1'b1;
          end else begin
            err_nxt     = 1'b1;
          end
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_hold <= '0;
      tx_shft <= '0;
      rx_shft <= '0;
      rx_data <= '0;
      bit_cnt <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_shft <= tx_shft_nxt;
      rx_shft <= rx_shft_nxt;
      rx_data <= rx_data_nxt;
      bit_cnt <= bit_cnt_nxt;
      rdy     <= rdy_nxt;
      frm_err <= err_nxt;
      if (wrt)
        tx_hold <= tx_data;
    end
  end

  assign busy = (state != IDLE);

`ifdef SPI_RESP_TRISTATE_EN
  assign MISO = busy ? tx_shft[WIDTH-1] : 1'bz;
`else
  assign MISO = busy ? tx_shft[WIDTH-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_resp.sv
// Bench for spi_resp: task-driven SPI master with a word-level reference of expected rx/MISO/pulses.
module tb_spi_resp;
  localparam int W = 16;

  logic         clk = 0, rst_n = 0;
  logic         SS_n = 1, SCLK = 1, MOSI = 0, wrt = 0;
  logic [W-1:0] tx_data = '0;
  logic         MISO, rdy, frm_err, busy;
  logic [W-1:0] rx_data;

  int checks = 0, errors = 0;
  int rdy_cnt = 0, err_cnt = 0;
  logic [W-1:0] model_hold = '0, model_rx = '0;

  spi_resp #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .wrt(wrt), .tx_data(tx_data), .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rdy) rdy_cnt++;
    if (frm_err) err_cnt++;
    if (rdy || frm_err) begin
      checks++;
      if (rdy && frm_err) begin
        errors++;
        $display("FAIL excl: rdy=%b frm_err=%b both high", rdy, frm_err);
      end
    end
  end

`ifdef SPI_RESP_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  task automatic do_wrt(input logic [W-1:0] v);
    tx_data = v; wrt = 1;
    @(negedge clk);
    wrt = 0;
    model_hold = v;
  endtask

  // n SCLK rises at a 16-clk half-period; optional wrt at rise index wat
  task automatic frame(input logic [W-1:0] w, input int n, input bit dw, input int wat,
                       input logic [W-1:0] wv, output logic [W-1:0] got);
    got = '0;
    SS_n = 0; MOSI = w[W-1];
    repeat (16) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      SCLK = 0;
      MOSI = (i < W) ? w[W-1-i] : 1'b0;
      if (dw && i == wat) begin tx_data = wv; wrt = 1; end
      @(negedge clk);
      if (dw && i == wat) begin wrt = 0; model_hold = wv; end
      repeat (15) @(negedge clk);
      SCLK = 1;
      if (i < W) got[W-1-i] = MISO;
      repeat (16) @(negedge clk);
    end
    SS_n = 1;
    repeat (12) @(negedge clk);
  endtask

  function automatic logic [W-1:0] exp_miso(input logic [W-1:0] h, input int n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < n && i < W; i++) r[W-1-i] = h[W-1-i];
    return r;
  endfunction

  // Runs one frame and checks it against the reference model
  task automatic run_check(input string nm, input logic [W-1:0] w, input int n,
                           input bit dw, input int wat, input logic [W-1:0] wv);
    logic [W-1:0] got, h;
    int r0, e0;
    bit ok;
    h = model_hold; r0 = rdy_cnt; e0 = err_cnt;
    frame(w, n, dw, wat, wv, got);
    ok = (n == W);
    if (ok) model_rx = w;
    checks++;
    if (rdy_cnt - r0 !== (ok ? 1 : 0) || err_cnt - e0 !== (ok ? 0 : 1)) begin
      errors++;
      $display("FAIL %s pulses: rdy=%0d err=%0d n=%0d", nm, rdy_cnt - r0, err_cnt - e0, n);
    end
    checks++;
    if (rx_data !== model_rx) begin
      errors++;
      $display("FAIL %s rx_data: got %h want %h", nm, rx_data, model_rx);
    end
    checks++;
    if (got !== exp_miso(h, n)) begin
      errors++;
      $display("FAIL %s miso: got %h want %h", nm, got, exp_miso(h, n));
    end
    checks++;
    if (busy !== 1'b0 || MISO !== MISO_IDLE) begin
      errors++;
      $display("FAIL %s idle: busy=%b MISO=%b", nm, busy, MISO);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (rx_data !== '0 || rdy !== 0 || frm_err !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL reset: rx=%h rdy=%b err=%b busy=%b want 0", rx_data, rdy, frm_err, busy);
    end
    checks++;
    if (MISO !== MISO_IDLE) begin
      errors++;
      $display("FAIL reset_miso: got %b want %b", MISO, MISO_IDLE);
    end
  endtask

  task automatic test_basic;
    do_wrt(16'hA5C3);
    run_check("basic", 16'h3C96, 16, 0, 0, '0);
  endtask

  task automatic test_back_to_back;
    do_wrt(16'hFFFF);
    run_check("b2b1", 16'h5A5A, 16, 1, 5, 16'h1234);
    run_check("b2b2", 16'hC3C3, 16, 0, 0, '0);
  endtask

  task automatic test_short_long;
    run_check("short9", 16'hFACE, 9, 0, 0, '0);
    run_check("long17", 16'hBEEF, 17, 0, 0, '0);
  endtask

  task automatic test_skip_abort;
    int e0;
    e0 = err_cnt;
    do_wrt(16'h8001);
    SS_n = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || MISO !== 1'b1) begin
      errors++;
      $display("FAIL skip_busy: busy=%b MISO=%b want 1 1", busy, MISO);
    end
    SS_n = 1;
    repeat (10) @(negedge clk);
    checks++;
    if (err_cnt - e0 !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL skip_abort: err=%0d busy=%b want 1 0", err_cnt - e0, busy);
    end
    run_check("reload", 16'h0001, 16, 0, 0, '0);
  endtask

  task automatic test_reset_mid;
    int r0, e0;
    logic [W-1:0] got;
    r0 = rdy_cnt; e0 = err_cnt;
    SS_n = 0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < W; i++) begin
      SCLK = 0; MOSI = i[0];
      repeat (16) @(negedge clk);
      SCLK = 1;
      if (i == 7) begin
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        model_hold = '0; model_rx = '0;
      end
      repeat (16) @(negedge clk);
    end
    SS_n = 1;
    repeat (12) @(negedge clk);
    checks++;
    if (rdy_cnt != r0 || err_cnt != e0 || rx_data !== '0) begin
      errors++;
      $display("FAIL rst_mid: rdy=%0d err=%0d rx=%h want 0 0 0", rdy_cnt - r0, err_cnt - e0, rx_data);
    end
    run_check("post_rst", 16'h0F0F, 16, 0, 0, '0);
    got = '0;
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      int n;
      do_wrt(W'($urandom));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : W;
      run_check("rand", W'($urandom), n, $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), W'($urandom));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    test_reset;
    test_basic;
    test_back_to_back;
    test_short_long;
    test_skip_abort;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
